// File: rtl/spi_mailbox.sv
// SPI slave mailbox. Opcode-led frames from the MCU push command bytes into a FIFO
// for the coprocessor, or read back coprocessor-written status bytes or the FIFO count.
module spi_mailbox #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int STATUS_BYTES = 4,
    parameter bit LSB_FIRST    = 1'b1,
    localparam int PTR_W  = $clog2(FIFO_DEPTH),
    localparam int CNT_W  = PTR_W + 1,
    localparam int ADDR_W = $clog2(STATUS_BYTES),
    localparam int BIT_W  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_nss,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  cmd_valid,
    input  logic                  cmd_pop,
    output logic [CNT_W-1:0]      fifo_count,
    output logic                  overflow,
    input  logic                  status_wr_en,
    input  logic [ADDR_W-1:0]     status_wr_addr,
    input  logic [DATA_WIDTH-1:0] status_wr_data,
    output logic                  frame_active
);

    typedef enum logic [2:0] {
        WAIT_IDLE, IDLE, OPCODE, WRITE_CMD, READ_STATUS, READ_COUNT, DISCARD
    } state_t;

    state_t                state;
    logic [1:0]            nss_sync;
    logic [2:0]            sck_sync;
    logic [1:0]            mosi_sync;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] rx_sh, rx_next, tx_sh, tx_next;
    logic [ADDR_W-1:0]     st_idx;
    logic                  push_pend, flush_req;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] status_regs [STATUS_BYTES];
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic                  nss_s, mosi_s, sck_rise, sck_fall, last_bit;
    logic                  fifo_full, do_pop, do_push;

    // nss resets to "asserted" so a frame already open at reset is never mistaken for idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            nss_sync  <= '0;
            sck_sync  <= '0;
            mosi_sync <= '0;
        end else begin
            nss_sync  <= {nss_sync[0], spi_nss};
            sck_sync  <= {sck_sync[1:0], spi_sck};
            mosi_sync <= {mosi_sync[0], spi_mosi};
        end
    end

    assign nss_s    = nss_sync[1];
    assign mosi_s   = mosi_sync[1];
    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign sck_fall = ~sck_sync[1] & sck_sync[2];
    assign last_bit = sck_rise && (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign rx_next  = LSB_FIRST ? {mosi_s, rx_sh[DATA_WIDTH-1:1]} : {rx_sh[DATA_WIDTH-2:0], mosi_s};
    assign tx_next  = LSB_FIRST ? (tx_sh >> 1) : (tx_sh << 1);
    assign spi_miso = (state == READ_STATUS || state == READ_COUNT) &&
                      (LSB_FIRST ? tx_sh[0] : tx_sh[DATA_WIDTH-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WAIT_IDLE;
            bit_cnt      <= '0;
            rx_sh        <= '0;
            tx_sh        <= '0;
            st_idx       <= '0;
            push_pend    <= 1'b0;
            push_data    <= '0;
            flush_req    <= 1'b0;
            frame_active <= 1'b0;
        end else begin
            push_pend    <= 1'b0;
            flush_req    <= 1'b0;
            frame_active <= (state != WAIT_IDLE) && !nss_s;
            if (nss_s) begin
                state   <= IDLE;
                bit_cnt <= '0;
            end else if (state == IDLE) begin
                state <= OPCODE;
            end else if (state != WAIT_IDLE && state != DISCARD) begin
                if (sck_rise) begin
                    rx_sh   <= rx_next;
                    bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);
                end
                // The fall right after a byte boundary must keep the freshly loaded bit 0.
                if (sck_fall && bit_cnt != '0) tx_sh <= tx_next;
                if (last_bit) begin
                    case (state)
                        OPCODE: begin
                            case (rx_next)
                                DATA_WIDTH'(1): state <= WRITE_CMD;
                                DATA_WIDTH'(2): begin
                                    state  <= READ_STATUS;
                                    tx_sh  <= status_regs[0];
                                    st_idx <= ADDR_W'(1);
                                end
                                DATA_WIDTH'(3): begin
                                    state <= READ_COUNT;
                                    tx_sh <= DATA_WIDTH'(fifo_count);
                                end
                                DATA_WIDTH'(4): begin
                                    state     <= DISCARD;
                                    flush_req <= 1'b1;
                                end
                                default: state <= DISCARD;
                            endcase
                        end
                        WRITE_CMD: begin
                            push_pend <= 1'b1;
                            push_data <= rx_next;
                        end
                        READ_STATUS: begin
                            tx_sh  <= status_regs[st_idx];
                            st_idx <= st_idx + ADDR_W'(1);
                        end
                        READ_COUNT: tx_sh <= DATA_WIDTH'(fifo_count);
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_regs <= '{default: '0};
        end else if (status_wr_en) begin
            status_regs[status_wr_addr] <= status_wr_data;
        end
    end

    assign cmd_valid = (fifo_count != '0);
    assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign do_pop    = cmd_pop && cmd_valid;
    assign do_push   = push_pend && (!fifo_full || do_pop);
    assign cmd_data  = cmd_valid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset || flush_req) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_pend && !do_push) overflow <= 1'b1;
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: the FIFO storage has no reset; cmd_data is masked while empty, so stale
    // entries are never visible and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push && !flush_req) fifo_mem[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_spi_mailbox.sv
// Directed bench for spi_mailbox: drives SPI mode-0 frames LSB first with a slow sck
// and compares FIFO, status readback and overflow behaviour against hand-computed values.
module tb_spi_mailbox;

    logic       clk;
    logic       reset;
    logic       spi_nss, spi_sck, spi_mosi, spi_miso;
    logic [7:0] cmd_data;
    logic       cmd_valid, cmd_pop;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       status_wr_en;
    logic [1:0] status_wr_addr;
    logic [7:0] status_wr_data;
    logic       frame_active;

    int         checks = 0;
    int         errors = 0;
    logic       pop_on_last;
    logic [7:0] rx_buf [8];
    logic [7:0] rx_tmp;

    spi_mailbox dut (
        .clk            (clk),
        .reset          (reset),
        .spi_nss        (spi_nss),
        .spi_sck        (spi_sck),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .cmd_data       (cmd_data),
        .cmd_valid      (cmd_valid),
        .cmd_pop        (cmd_pop),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .status_wr_en   (status_wr_en),
        .status_wr_addr (status_wr_addr),
        .status_wr_data (status_wr_data),
        .frame_active   (frame_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    // One byte (or a partial byte), LSB first; MISO is sampled just before each rising edge.
    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[i];
            half();
            rx[i] = spi_miso;
            spi_sck = 1'b1;
            if (pop_on_last && i == 7) begin
                // Push lands 2 sync flops + 1 edge-detect + 1 clk after the rise.
                repeat (3) @(negedge clk);
                cmd_pop = 1'b1;
                @(negedge clk);
                cmd_pop = 1'b0;
                repeat (4) @(negedge clk);
            end else begin
                half();
            end
            spi_sck = 1'b0;
        end
    endtask

    task automatic begin_frame();
        spi_nss = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic end_frame();
        half();
        spi_nss = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Byte b of the frame sits in bytes[8*b +: 8].
    task automatic send_frame(input int n, input logic [63:0] bytes);
        begin_frame();
        for (int b = 0; b < n; b++) spi_byte(bytes[8*b +: 8], 8, rx_buf[b]);
        end_frame();
    endtask

    task automatic pop_one();
        cmd_pop = 1'b1;
        @(negedge clk);
        cmd_pop = 1'b0;
        @(negedge clk);
    endtask

    task automatic write_status(input logic [1:0] addr, input logic [7:0] data);
        status_wr_en   = 1'b1;
        status_wr_addr = addr;
        status_wr_data = data;
        @(negedge clk);
        status_wr_en   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        spi_nss = 1'b1;
        spi_sck = 1'b0;
        spi_mosi = 1'b0;
        cmd_pop = 1'b0;
        status_wr_en = 1'b0;
        status_wr_addr = '0;
        status_wr_data = '0;
        pop_on_last = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid", cmd_valid, 0);
        check("rst_data", cmd_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_miso", spi_miso, 0);
        check("rst_frame_active", frame_active, 0);
        repeat (5) @(negedge clk);

        // Basic write frame, then drain in order.
        send_frame(4, {8'd219, 8'd105, 8'd145, 8'h01});
        check("wr_head", cmd_data, 145);
        check("wr_count", fifo_count, 3);
        check("wr_overflow", overflow, 0);
        pop_one();
        check("pop1_data", cmd_data, 105);
        pop_one();
        check("pop2_data", cmd_data, 219);
        pop_one();
        check("pop3_valid", cmd_valid, 0);
        check("pop3_count", fifo_count, 0);
        pop_one();
        check("pop_empty_count", fifo_count, 0);

        // Overflow: fifth byte dropped, then flush clears everything.
        send_frame(6, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'h01});
        check("ovf_count", fifo_count, 4);
        check("ovf_flag", overflow, 1);
        for (int i = 1; i <= 4; i++) begin
            check("ovf_contents", cmd_data, i);
            pop_one();
        end
        check("ovf_drained", cmd_valid, 0);
        check("ovf_sticky", overflow, 1);
        send_frame(3, {8'd8, 8'd9, 8'h01});
        check("refill_count", fifo_count, 2);
        send_frame(1, {56'd0, 8'h04});
        check("flush_count", fifo_count, 0);
        check("flush_overflow", overflow, 0);
        check("flush_valid", cmd_valid, 0);

        // Status readback with index wrap.
        write_status(2'd0, 8'd31);
        write_status(2'd1, 8'd85);
        write_status(2'd2, 8'd131);
        write_status(2'd3, 8'd200);
        send_frame(6, {40'd0, 8'h02});
        check("st_opcode_miso", rx_buf[0], 0);
        check("st_byte1", rx_buf[1], 31);
        check("st_byte2", rx_buf[2], 85);
        check("st_byte3", rx_buf[3], 131);
        check("st_byte4", rx_buf[4], 200);
        check("st_byte5_wrap", rx_buf[5], 31);
        check("st_idle_miso", spi_miso, 0);

        // Partial byte aborted by nss: no push; count readback reflects prior count.
        send_frame(3, {8'h55, 8'hAA, 8'h01});
        check("pre_partial_count", fifo_count, 2);
        begin_frame();
        spi_byte(8'h01, 8, rx_tmp);
        spi_byte(8'hFF, 5, rx_tmp);
        end_frame();
        check("partial_count", fifo_count, 2);
        check("partial_head", cmd_data, 8'hAA);
        send_frame(3, {16'd0, 8'h03});
        check("rdcnt_byte1", rx_buf[1], 2);
        check("rdcnt_byte2", rx_buf[2], 2);

        // Reset mid-frame with nss held low.
        begin_frame();
        spi_byte(8'h01, 8, rx_tmp);
        spi_byte(8'hC3, 3, rx_tmp);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_count", fifo_count, 0);
        spi_byte(8'hC3, 5, rx_tmp);
        spi_byte(8'h66, 8, rx_tmp);
        end_frame();
        check("midrst_no_push", fifo_count, 0);
        check("midrst_valid", cmd_valid, 0);
        send_frame(2, {8'd77, 8'h01});
        check("post_rst_count", fifo_count, 1);
        check("post_rst_data", cmd_data, 77);
        pop_one();

        // Push and pop in the same clk while full.
        send_frame(5, {8'd40, 8'd30, 8'd20, 8'd10, 8'h01});
        check("full_count", fifo_count, 4);
        begin_frame();
        check("frame_active_low_nss", frame_active, 1);
        spi_byte(8'h01, 8, rx_tmp);
        pop_on_last = 1'b1;
        spi_byte(8'd50, 8, rx_tmp);
        pop_on_last = 1'b0;
        end_frame();
        check("frame_active_idle", frame_active, 0);
        check("pp_count", fifo_count, 4);
        check("pp_overflow", overflow, 0);
        for (int i = 2; i <= 5; i++) begin
            check("pp_order", cmd_data, 10 * i);
            pop_one();
        end
        check("pp_drained", cmd_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
